// File: rtl/mul_pipe_issue_if.sv
// Bundle of the operand handshake, the cell-0 launch bus and the credit/status
// signals of the multiplier issue stage. The master drives operands and credit
// returns; the slave (the issue stage) drives in_ready, cell_* and status.
interface mul_pipe_issue_if #(
  parameter int WIDTH_multiplicand = 16,
  parameter int WIDTH_multiplier   = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int CREDITS            = 8
);
  localparam int PROD_W = WIDTH_multiplicand + WIDTH_multiplier;
  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  // Operand handshake: a pair transfers on a clock edge where in_valid and
  // in_ready are both high; in_valid may not depend on in_ready, and the
  // pair must be held stable while in_valid is high and in_ready is low.
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH_multiplicand-1:0] in_multiplicand;
  logic [WIDTH_multiplier-1:0]   in_multiplier;

  // Launch bus into the first multiply cell.
  logic                          cell_valid;
  logic [PROD_W-1:0]             cell_multiplicand;
  logic [WIDTH_multiplier-1:0]   cell_multiplier;
  logic [PROD_W-1:0]             cell_product_in;

  // Credit return from the downstream result buffer and status.
  logic                          credit_return;
  logic [CRED_W-1:0]             credits_avail;
  logic [CNT_W-1:0]              fifo_count;
  logic                          credit_err;

  modport master (
    output in_valid, in_multiplicand, in_multiplier, credit_return,
    input  in_ready, cell_valid, cell_multiplicand, cell_multiplier,
           cell_product_in, credits_avail, fifo_count, credit_err
  );

  modport slave (
    input  in_valid, in_multiplicand, in_multiplier, credit_return,
    output in_ready, cell_valid, cell_multiplicand, cell_multiplier,
           cell_product_in, credits_avail, fifo_count, credit_err
  );
endinterface

// File: rtl/mul_pipe_issue.sv
// Issue stage feeding cell 0 of the shift-add multiplier chain. Operand pairs
// are buffered in a small FIFO and launched one per cycle while the downstream
// result buffer has credit. The cell chain never stalls, so the credit count
// is the only backpressure; a pair is launched only when its result is
// guaranteed a slot downstream.
module mul_pipe_issue #(
  parameter int WIDTH_multiplicand = 16,
  parameter int WIDTH_multiplier   = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int CREDITS            = 8
) (
  input logic             clk,
  input logic             rst,
  mul_pipe_issue_if.slave bus
);
  localparam int PROD_W  = WIDTH_multiplicand + WIDTH_multiplier;
  localparam int ENTRY_W = WIDTH_multiplicand + WIDTH_multiplier;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W  = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  // Operand storage: entry = {multiplicand, multiplier}.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_d;

  logic [CRED_W-1:0]  credits;
  logic [CRED_W-1:0]  credits_d;
  logic               err;
  logic               err_d;

  logic                          cell_valid_q;
  logic [PROD_W-1:0]             cell_mcand_q;
  logic [WIDTH_multiplier-1:0]   cell_mplier_q;

  logic               ready_w;
  logic               push_en;
  logic               issue_en;
  logic [ENTRY_W-1:0] head;

  // Ready comes only from the registered count: a pop in the same cycle does
  // not open a slot, so a full FIFO never writes through.
  assign ready_w  = (count < CNT_FULL);
  assign push_en  = bus.in_valid && ready_w;
  // Issue looks at start-of-cycle state only; a pair pushed this cycle is
  // not yet counted and therefore cannot be launched in the same cycle.
  assign issue_en = (count != '0) && (credits != '0);
  assign head     = mem[rd_ptr];

  // Operand storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= {bus.in_multiplicand, bus.in_multiplier};
    end
  end

  // Write and read pointers; depth is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (issue_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy next value: push and pop in the same cycle cancel.
  always_comb begin
    count_d = count;
    if (push_en && !issue_en) begin
      count_d = count + CNT_W'(1);
    end else if (!push_en && issue_en) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Credit next value and overflow detection; a return that would exceed
  // the buffer size is dropped and flagged.
  always_comb begin
    credits_d = credits;
    err_d     = err;
    if (issue_en && !bus.credit_return) begin
      credits_d = credits - CRED_W'(1);
    end else if (!issue_en && bus.credit_return) begin
      if (credits == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits + CRED_W'(1);
      end
    end
  end

  // Status registers: occupancy, credits and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      credits <= CRED_MAX;
      err     <= 1'b0;
    end else begin
      count   <= count_d;
      credits <= credits_d;
      err     <= err_d;
    end
  end

  // Launch register into cell 0; idle cycles drive zeros like an idle cell.
  always_ff @(posedge clk) begin
    if (!rst || !issue_en) begin
      cell_valid_q  <= 1'b0;
      cell_mcand_q  <= '0;
      cell_mplier_q <= '0;
    end else begin
      cell_valid_q  <= 1'b1;
      cell_mcand_q  <= PROD_W'(head[ENTRY_W-1:WIDTH_multiplier]);
      cell_mplier_q <= head[WIDTH_multiplier-1:0];
    end
  end

  assign bus.in_ready          = ready_w;
  assign bus.cell_valid        = cell_valid_q;
  assign bus.cell_multiplicand = cell_mcand_q;
  assign bus.cell_multiplier   = cell_mplier_q;
  assign bus.cell_product_in   = '0;
  assign bus.credits_avail     = credits;
  assign bus.fifo_count        = count;
  assign bus.credit_err        = err;
endmodule
